rtu_retire: RTL and testbench

RTU_RETIRE -- requirements
Module: rtu_retire

---
 rtl/rtu_retire_pkg.sv | 16 +
 rtl/rtu_retire_if.sv | 27 ++
 rtl/rtu_retire_rat.sv | 31 +++
 rtl/rtu_retire.sv | 93 +++++++++
 tb/tb_rtu_retire.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rtu_retire_pkg.sv
// Shared retire-unit definitions: FSM encoding, register-index widths and the default ROB depth.
package rtu_retire_pkg;
  localparam int ROB_DEPTH_DEF = 16;
  localparam int PREG_W        = 6;
  localparam int AREG_W        = 5;
  localparam int AREG_NUM      = 32;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FLUSH   = 2'b01,
    ST_RECOVER = 2'b10
  } state_e;
endpackage

// File: rtl/rtu_retire_if.sv
// Retire-side bus: head-entry retire strobe in, free-list release and RAT recovery out.
interface rtu_retire_if;
  import rtu_retire_pkg::*;

  logic  retire_vld;
  logic  retire_dst_vld;
  areg_t retire_dst;
  preg_t retire_pdst;
  logic  retire_jump;

  logic  free_vld;
  preg_t free_preg;
  logic  recover_vld;
  areg_t recover_idx;
  preg_t recover_preg;
  logic  recover_done;

  modport master (
    output retire_vld, retire_dst_vld, retire_dst, retire_pdst, retire_jump,
    input  free_vld, free_preg, recover_vld, recover_idx, recover_preg, recover_done
  );

  modport slave (
    input  retire_vld, retire_dst_vld, retire_dst, retire_pdst, retire_jump,
    output free_vld, free_preg, recover_vld, recover_idx, recover_preg, recover_done
  );
endinterface

// File: rtl/rtu_retire_rat.sv
// Committed RAT: 32 x 6, one write port, free-lookup and recovery read ports; entry 0 is hardwired to 0.
module rtu_retire_rat
  import rtu_retire_pkg::*;
(
  input  logic  clk,
  input  logic  rst_clk,
  input  logic  we,
  input  areg_t waddr,
  input  preg_t wdata,
  input  areg_t raddr_free,
  output preg_t rdata_free,
  input  areg_t raddr_rec,
  output preg_t rdata_rec
);

  preg_t mem [AREG_NUM];

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      for (int i = 0; i < AREG_NUM; i++) begin
        mem[i] <= preg_t'(i);
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_free = (raddr_free == '0) ? '0 : mem[raddr_free];
  assign rdata_rec  = (raddr_rec  == '0) ? '0 : mem[raddr_rec];

endmodule

// File: rtl/rtu_retire.sv
// Retire unit: advances the ROB head, commits RAT mappings, frees old pregs and
// sequences flush plus speculative-RAT recovery after a jump.
module rtu_retire
  import rtu_retire_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_clk,
  rtu_retire_if.slave          rt,
  output logic [ROB_DEPTH-1:0] head_iid_ptr,
  output logic                 rtu_global_flush,
  output logic                 rtu_stall,
  output logic [63:0]          instret
);

  state_e state, state_nxt;
  areg_t  rec_idx;
  preg_t  prior_preg;
  preg_t  rec_preg;
  logic   accept;
  logic   rat_we;
  logic   free_vld_p1;
  preg_t  free_preg_p1;
  logic   done_p1;

  assign accept = rt.retire_vld && (state == ST_IDLE);
  assign rat_we = accept && rt.retire_dst_vld && (rt.retire_dst != '0);

  rtu_retire_rat u_rat (
    .clk        (clk),
    .rst_clk    (rst_clk),
    .we         (rat_we),
    .waddr      (rt.retire_dst),
    .wdata      (rt.retire_pdst),
    .raddr_free (rt.retire_dst),
    .rdata_free (prior_preg),
    .raddr_rec  (rec_idx),
    .rdata_rec  (rec_preg)
  );

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (rt.retire_jump) state_nxt = ST_FLUSH;
      ST_FLUSH:   state_nxt = ST_RECOVER;
      ST_RECOVER: if (rec_idx == '1) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rtu_global_flush = (state == ST_FLUSH);
    rtu_stall        = (state != ST_IDLE);
    rt.recover_vld   = (state == ST_RECOVER);
    rt.recover_idx   = rt.recover_vld ? rec_idx  : '0;
    rt.recover_preg  = rt.recover_vld ? rec_preg : '0;
  end

  // p0 -> p1: head/instret/recovery index advance; the old mapping is captured for release
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      head_iid_ptr <= ROB_DEPTH'(1);
      instret      <= '0;
      rec_idx      <= '0;
      free_vld_p1  <= 1'b0;
      free_preg_p1 <= '0;
      done_p1      <= 1'b0;
    end else begin
      if (state == ST_FLUSH)
        head_iid_ptr <= ROB_DEPTH'(1);
      else if (accept)
        head_iid_ptr <= {head_iid_ptr[ROB_DEPTH-2:0], head_iid_ptr[ROB_DEPTH-1]};
      instret <= instret + 64'(accept);
      if (state == ST_FLUSH)        rec_idx <= areg_t'(1);
      else if (state == ST_RECOVER) rec_idx <= rec_idx + areg_t'(1);
      // A release is pointless when the old mapping is p0 or is being re-committed
      free_vld_p1 <= rat_we && (prior_preg != '0) && (prior_preg != rt.retire_pdst);
      if (rat_we) free_preg_p1 <= prior_preg;
      done_p1 <= (state == ST_RECOVER) && (state_nxt == ST_IDLE);
    end
  end

  assign rt.free_vld     = free_vld_p1;
  assign rt.free_preg    = free_preg_p1;
  assign rt.recover_done = done_p1;

endmodule

// File: tb/tb_rtu_retire.sv
// Scoreboard bench for rtu_retire: a cycle-level behavioural model queues expected outputs, a monitor compares.
module tb_rtu_retire;
  localparam int DEPTH = 16;

  typedef struct {
    int          head;
    logic [63:0] instret;
    logic        flush;
    logic        stall;
    logic        free_vld;
    logic [5:0]  free_preg;
    logic        rec_vld;
    logic [4:0]  rec_idx;
    logic [5:0]  rec_preg;
    logic        done;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_clk = 1'b1;
  logic [DEPTH-1:0]  head_iid_ptr;
  logic              rtu_global_flush;
  logic              rtu_stall;
  logic [63:0]       instret;

  rtu_retire_if rif ();

  rtu_retire #(.ROB_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_clk          (rst_clk),
    .rt               (rif),
    .head_iid_ptr     (head_iid_ptr),
    .rtu_global_flush (rtu_global_flush),
    .rtu_stall        (rtu_stall),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // Reference model: architectural view of the retire unit
  int          m_rat [32];
  int          m_head;
  logic [63:0] m_instret;
  int          m_seq;   // 0 idle, 1 flush, 2..32 recovering index m_seq-1

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    m_head    = 0;
    m_instret = '0;
    m_seq     = 0;
  endtask

  task automatic drive(input logic v, input logic dv, input logic [4:0] d,
                       input logic [5:0] p, input logic j);
    exp_t e;
    int   nseq;
    int   prior;
    @(negedge clk);
    rif.retire_vld     = v;
    rif.retire_dst_vld = dv;
    rif.retire_dst     = d;
    rif.retire_pdst    = p;
    rif.retire_jump    = j;
    e.free_vld  = 1'b0;
    e.free_preg = '0;
    e.done      = 1'b0;
    if (m_seq == 0) begin
      if (v) begin
        if (dv && d != 0) begin
          prior = m_rat[d];
          if (prior != 0 && prior != int'(p)) begin
            e.free_vld  = 1'b1;
            e.free_preg = 6'(prior);
          end
          m_rat[d] = int'(p);
        end
        m_head    = (m_head + 1) % DEPTH;
        m_instret = m_instret + 64'd1;
      end
      nseq = j ? 1 : 0;
    end else if (m_seq == 1) begin
      m_head = 0;
      nseq   = 2;
    end else begin
      nseq   = (m_seq == 32) ? 0 : m_seq + 1;
      e.done = (m_seq == 32);
    end
    m_seq     = nseq;
    e.flush   = (nseq == 1);
    e.stall   = (nseq != 0);
    e.rec_vld = (nseq >= 2);
    e.rec_idx = (nseq >= 2) ? 5'(nseq - 1) : 5'd0;
    e.rec_preg = (nseq >= 2) ? 6'(m_rat[nseq - 1]) : 6'd0;
    e.head    = m_head;
    e.instret = m_instret;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_clk            = 1'b0;
    rif.retire_vld     = 1'b0;
    rif.retire_dst_vld = 1'b0;
    rif.retire_dst     = '0;
    rif.retire_pdst    = '0;
    rif.retire_jump    = 1'b0;
    #1;
    chk("rst_head",    64'(head_iid_ptr),     64'h1);
    chk("rst_instret", instret,               64'h0);
    chk("rst_flush",   64'(rtu_global_flush), 64'h0);
    chk("rst_stall",   64'(rtu_stall),        64'h0);
    chk("rst_free",    {57'd0, rif.free_vld, rif.free_preg}, 64'h0);
    chk("rst_recover", {51'd0, rif.recover_vld, rif.recover_idx, rif.recover_preg}, 64'h0);
    chk("rst_done",    64'(rif.recover_done), 64'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_clk = 1'b1;
  endtask

  // Monitor: compares DUT outputs just after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("head",     64'(head_iid_ptr),     64'(1) << e.head);
        chk("instret",  instret,               e.instret);
        chk("flush",    64'(rtu_global_flush), 64'(e.flush));
        chk("stall",    64'(rtu_stall),        64'(e.stall));
        chk("free_vld", 64'(rif.free_vld),     64'(e.free_vld));
        if (e.free_vld) chk("free_preg", 64'(rif.free_preg), 64'(e.free_preg));
        chk("rec_vld",  64'(rif.recover_vld),  64'(e.rec_vld));
        if (e.rec_vld) begin
          chk("rec_idx",  64'(rif.recover_idx),  64'(e.rec_idx));
          chk("rec_preg", 64'(rif.recover_preg), 64'(e.rec_preg));
        end
        chk("rec_done", 64'(rif.recover_done), 64'(e.done));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] d;
    logic [5:0] p;
    model_reset();
    rif.retire_vld     = 1'b0;
    rif.retire_dst_vld = 1'b0;
    rif.retire_dst     = '0;
    rif.retire_pdst    = '0;
    rif.retire_jump    = 1'b0;
    do_reset();

    // single committed write, then old mapping released
    drive(1'b1, 1'b1, 5'd5, 6'd40, 1'b0);
    idle(2);

    // full wrap of the head pointer without destinations
    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b0, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 1'b0);
    idle(1);

    // writes to x0 are dropped
    drive(1'b1, 1'b1, 5'd0, 6'd33, 1'b0);
    idle(1);

    // retire then jump: flush + full recovery with retires/jumps ignored mid-way
    drive(1'b1, 1'b1, 5'd3, 6'd50, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 6'd0, 1'b1);
    for (int i = 0; i < 33; i++) begin
      if (i == 5 || i == 20) drive(1'b1, 1'b1, 5'd7, 6'd20, 1'b1);
      else                   drive(1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
    end
    idle(2);

    // reset while recovering index 10
    drive(1'b1, 1'b1, 5'd9, 6'd12, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 6'd0, 1'b1);
    for (int i = 0; i < 40 && m_seq != 11; i++) idle(1);
    do_reset();
    idle(3);
    drive(1'b0, 1'b0, 5'd0, 6'd0, 1'b1);
    idle(34);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      d = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0, 1:    p = 6'(m_rat[d]);
        2:       p = 6'd0;
        default: p = 6'($urandom_range(0, 63));
      endcase
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), d, p,
            1'($urandom_range(0, 39) == 0));
    end
    idle(34);

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
